// File: rtl/ternary_vec_engine_if.sv
// Start/busy/done bus of the ternary vector engine.
// Carries operands in and the committed result out.
interface ternary_vec_engine_if #(
    parameter int N = 16,
    parameter int W = 16
);
    logic             start;
    logic [1:0]       mode;
    logic [N*W-1:0]   vec_a;
    logic [N*W-1:0]   vec_b;
    logic [N*N*2-1:0] mat;
    logic             busy;
    logic             done;
    logic             sat;
    logic [N*W-1:0]   result;

    modport master (
        output start, mode, vec_a, vec_b, mat,
        input  busy, done, sat, result
    );

    modport slave (
        input  start, mode, vec_a, vec_b, mat,
        output busy, done, sat, result
    );
endinterface

// File: rtl/ternary_vec_engine.sv
// Vector ADD/SUB/MUL and ternary matrix x vector engine.
// One output element per cycle, result committed on done.
module ternary_vec_engine #(
    parameter int N    = 16,
    parameter int W    = 16,
    parameter int FRAC = 8
) (
    input logic                 clk,
    input logic                 rst,
    ternary_vec_engine_if.slave bus
);
    localparam int KW = $clog2(N);
    localparam int AW = W + $clog2(N) + 1;
    localparam int XW = (2 * W > AW) ? 2 * W : AW;
    localparam logic [KW-1:0] LAST = KW'(N - 1);
    localparam logic signed [XW-1:0] MAXV =
        {{(XW - W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [XW-1:0] MINV =
        {{(XW - W + 1){1'b1}}, {(W - 1){1'b0}}};

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]          mode_q;
    logic signed [W-1:0] a_q  [N];
    logic signed [W-1:0] b_q  [N];
    logic [1:0]          w_q  [N][N];
    logic signed [W-1:0] work [N];
    logic [KW-1:0]       k;
    logic                sat_run;
    logic                accept;
    logic                last;
    logic signed [XW-1:0] wide;
    logic signed [W-1:0]  elem;
    logic                 clamp;

    assign bus.busy = (state == RUN);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: accept when idle, leave RUN after the last element.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (k == LAST) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Element k at a width that cannot wrap, then clamp to W bits.
    always_comb begin
        logic signed [XW-1:0] ax;
        logic signed [XW-1:0] bx;
        logic signed [XW-1:0] aj;
        logic signed [XW-1:0] acc;
        logic [1:0]           w;
        ax    = {{(XW - W){a_q[k][W-1]}}, a_q[k]};
        bx    = {{(XW - W){b_q[k][W-1]}}, b_q[k]};
        aj    = '0;
        acc   = '0;
        w     = '0;
        wide  = '0;
        elem  = '0;
        clamp = 1'b0;
        unique case (mode_q)
            2'd0: wide = ax + bx;
            2'd1: wide = ax - bx;
            2'd2: wide = (ax * bx) >>> FRAC;
            default: begin
                for (int j = 0; j < N; j++) begin
                    aj = {{(XW - W){a_q[j][W-1]}}, a_q[j]};
                    w  = w_q[k][j];
                    if (w[0]) begin
                        acc = w[1] ? acc - aj : acc + aj;
                    end
                end
                wide = acc;
            end
        endcase
        if (wide > MAXV) begin
            elem  = MAXV[W-1:0];
            clamp = 1'b1;
        end else if (wide < MINV) begin
            elem  = MINV[W-1:0];
            clamp = 1'b1;
        end else begin
            elem = wide[W-1:0];
        end
    end

    // Snapshot on accept, fill the buffer, commit result on the last element.
    always_ff @(posedge clk) begin
        if (rst) begin
            k          <= '0;
            sat_run    <= 1'b0;
            mode_q     <= '0;
            bus.done   <= 1'b0;
            bus.sat    <= 1'b0;
            bus.result <= '0;
            for (int i = 0; i < N; i++) begin
                work[i] <= '0;
                a_q[i]  <= '0;
                b_q[i]  <= '0;
                for (int j = 0; j < N; j++) begin
                    w_q[i][j] <= '0;
                end
            end
        end else begin
            bus.done <= last;
            if (accept) begin
                mode_q  <= bus.mode;
                k       <= '0;
                sat_run <= 1'b0;
                for (int i = 0; i < N; i++) begin
                    a_q[i] <= bus.vec_a[i*W +: W];
                    b_q[i] <= bus.vec_b[i*W +: W];
                    for (int j = 0; j < N; j++) begin
                        w_q[i][j] <= bus.mat[(i*N + j)*2 +: 2];
                    end
                end
            end
            if (state == RUN) begin
                work[k] <= elem;
                sat_run <= sat_run | clamp;
                k       <= last ? '0 : k + KW'(1);
            end
            if (last) begin
                bus.sat <= sat_run | clamp;
                for (int i = 0; i < N; i++) begin
                    bus.result[i*W +: W] <= (i == N - 1) ? elem : work[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_ternary_vec_engine.sv
// Randomised and directed bench for ternary_vec_engine.
// A cycle-level reference model is checked on every negedge.
module tb_ternary_vec_engine;
    localparam int N    = 4;
    localparam int W    = 8;
    localparam int FRAC = 4;
    localparam int MAXI = 2 ** (W - 1) - 1;
    localparam int MINI = -(2 ** (W - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    ternary_vec_engine_if #(.N(N), .W(W)) bus ();

    ternary_vec_engine #(.N(N), .W(W), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference arithmetic straight from the operation definitions.
    function automatic void ref_op(input logic [1:0] m,
                                   input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic [31:0] mt,
                                   output logic [31:0] r,
                                   output logic s);
        int ea[N];
        int eb[N];
        r = '0;
        s = 1'b0;
        for (int i = 0; i < N; i++) begin
            ea[i] = int'($signed(a[i*W +: W]));
            eb[i] = int'($signed(b[i*W +: W]));
        end
        for (int k = 0; k < N; k++) begin
            int v;
            logic [1:0] w;
            v = 0;
            case (m)
                2'd0: v = ea[k] + eb[k];
                2'd1: v = ea[k] - eb[k];
                2'd2: v = (ea[k] * eb[k]) >>> FRAC;
                default: begin
                    for (int j = 0; j < N; j++) begin
                        w = mt[(k*N + j)*2 +: 2];
                        if (w == 2'b01) v += ea[j];
                        else if (w == 2'b11) v -= ea[j];
                    end
                end
            endcase
            if (v > MAXI) begin
                v = MAXI;
                s = 1'b1;
            end else if (v < MINI) begin
                v = MINI;
                s = 1'b1;
            end
            r[k*W +: W] = W'(v);
        end
    endfunction

    // Timing model: an accepted op completes N+1 cycles later.
    int          rem        = 0;
    logic        exp_busy   = 1'b0;
    logic        exp_done   = 1'b0;
    logic        exp_sat    = 1'b0;
    logic [31:0] exp_result = '0;
    logic [31:0] pend_res   = '0;
    logic        pend_sat   = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            rem        = 0;
            exp_busy   = 1'b0;
            exp_done   = 1'b0;
            exp_sat    = 1'b0;
            exp_result = '0;
        end else begin
            exp_done = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    exp_done   = 1'b1;
                    exp_result = pend_res;
                    exp_sat    = pend_sat;
                end
            end else if (bus.start) begin
                ref_op(bus.mode, bus.vec_a, bus.vec_b, bus.mat,
                       pend_res, pend_sat);
                rem = N;
            end
            exp_busy = (rem > 0);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        vectors++;
        if (bus.busy !== exp_busy || bus.done !== exp_done ||
            bus.sat !== exp_sat || bus.result !== exp_result) begin
            miscompares++;
            $display("FAIL cycle t=%0t got busy=%b done=%b sat=%b res=%h need busy=%b done=%b sat=%b res=%h",
                     $time, bus.busy, bus.done, bus.sat, bus.result,
                     exp_busy, exp_done, exp_sat, exp_result);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] need);
        vectors++;
        if (got !== need) begin
            miscompares++;
            $display("FAIL %s: got %h need %h", nm, got, need);
        end
    endtask

    function automatic logic [31:0] pk(input int e0, input int e1,
                                       input int e2, input int e3);
        return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    function automatic logic [31:0] rvec();
        logic [31:0] v;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(3))
                0: v[i*W +: W] = 8'h7F;
                1: v[i*W +: W] = 8'h80;
                default: v[i*W +: W] = 8'($urandom);
            endcase
        end
        return v;
    endfunction

    // Called at a negedge while idle or in a done cycle.
    task automatic run_op(input string nm, input logic [1:0] m,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] mt, input logic [31:0] er,
                          input logic es);
        int cyc;
        int nb;
        bus.start = 1'b1;
        bus.mode  = m;
        bus.vec_a = a;
        bus.vec_b = b;
        bus.mat   = mt;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        nb  = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (bus.busy === 1'b1) nb++;
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_latency"}, cyc, N + 1);
        chk({nm, "_busycyc"}, nb, N);
        chk({nm, "_result"}, bus.result, er);
        chk({nm, "_sat"}, {31'd0, bus.sat}, {31'd0, es});
        chk({nm, "_model"}, exp_result, er);
    endtask

    initial begin
        int cyc;
        int seen;
        bus.start = 1'b0;
        bus.mode  = '0;
        bus.vec_a = '0;
        bus.vec_b = '0;
        bus.mat   = '0;
        repeat (2) @(negedge clk);
        chk("reset_result", bus.result, 32'd0);
        chk("reset_flags", {29'd0, bus.busy, bus.done, bus.sat}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("add", 2'd0, pk(1, 2, 3, 4), pk(10, 20, 30, 40), '0,
               pk(11, 22, 33, 44), 1'b0);
        run_op("sub", 2'd1, pk(-128, 0, 127, 5), pk(1, 0, -1, 5), '0,
               pk(-128, 0, 127, 0), 1'b1);
        run_op("mul", 2'd2, pk(32, 16, 127, -16), pk(32, 48, 127, 16), '0,
               pk(64, 48, 127, -16), 1'b1);
        run_op("matvec", 2'd3, pk(1, 2, 3, 4), '0, 32'h0031FF55,
               pk(10, -10, -2, 0), 1'b0);
        run_op("mv_satp", 2'd3, pk(127, 127, 127, 127), '0, 32'h00000055,
               pk(127, 0, 0, 0), 1'b1);
        run_op("mv_neg", 2'd3, pk(1, 1, 1, 1), '0, 32'h000000FF,
               pk(-4, 0, 0, 0), 1'b0);
        run_op("mv_negmin", 2'd3, pk(-128, 0, 0, 0), '0, 32'h00000003,
               pk(127, 0, 0, 0), 1'b1);

        // Start held high; operands change right after accept.
        bus.start = 1'b1;
        bus.mode  = 2'd0;
        bus.vec_a = pk(1, 2, 3, 4);
        bus.vec_b = pk(5, 5, 5, 5);
        @(posedge clk);
        @(negedge clk);
        bus.mode  = 2'd2;
        bus.vec_a = pk(100, 100, 100, 100);
        bus.vec_b = pk(100, 100, 100, 100);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("hold_latency", cyc, N + 1);
        chk("hold_snapshot", bus.result, pk(6, 7, 8, 9));
        @(negedge clk);
        chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_result", bus.result, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        chk("abort_nodone", seen, 0);
        run_op("after_abort", 2'd0, pk(-100, 100, 50, -50),
               pk(-100, 100, 50, -50), '0, pk(-128, 127, 100, -100), 1'b1);

        // Random traffic, including start while busy and stray resets.
        for (int c = 0; c < 4000; c++) begin
            bus.start = ($urandom_range(2) == 0);
            bus.mode  = 2'($urandom_range(3));
            bus.vec_a = rvec();
            bus.vec_b = rvec();
            bus.mat   = $urandom;
            rst       = ($urandom_range(299) == 0);
            @(negedge clk);
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (N + 3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
